// File: rtl/fixed_to_fp_pipe.sv
// Three-stage converter from a signed fixed-point sum plus block exponent to a packed
// float, with round-to-nearest-even, saturation to infinity and flush-to-zero.
module fixed_to_fp_pipe #(
  parameter int DATA_WIDTH  = 51,
  parameter int FIXED_POINT = 46,
  parameter int EXP_W       = 8,
  parameter int MANT_W      = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_fixed,
  input  logic [7:0]            in_exp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] out_fp,
  output logic [3:0]            out_flags
);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int PW   = $clog2(DATA_WIDTH);
  localparam int SW   = MANT_W + 1;

  logic en;
  logic v1;
  logic v2;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic                  s1_sign;
  logic [DATA_WIDTH-1:0] s1_mag;
  logic [7:0]            s1_exp;

  // Negating the most-negative input yields 2^(DATA_WIDTH-1), which is exact as unsigned.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign <= in_fixed[DATA_WIDTH-1];
      s1_mag  <= in_fixed[DATA_WIDTH-1] ? -in_fixed : in_fixed;
      s1_exp  <= in_exp;
    end
  end

  logic [PW-1:0]      lead;
  int                 sh;
  logic [SW-1:0]      norm_sig;
  logic               norm_guard;
  logic               norm_sticky;
  logic signed [11:0] norm_e;

  always_comb begin
    lead = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (s1_mag[i]) lead = PW'(i);
    end
  end

  always_comb begin
    sh          = int'(lead) - MANT_W;
    norm_guard  = 1'b0;
    norm_sticky = 1'b0;
    if (sh > 0) begin
      norm_sig = SW'(s1_mag >> sh);
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i == sh - 1)     norm_guard  = s1_mag[i];
        else if (i < sh - 1) norm_sticky = norm_sticky | s1_mag[i];
      end
    end else begin
      norm_sig = SW'(s1_mag << (MANT_W - int'(lead)));
    end
    norm_e = 12'(int'($signed(s1_exp)) + int'(lead) - FIXED_POINT + BIAS);
  end

  logic               s2_sign;
  logic               s2_guard;
  logic               s2_sticky;
  logic [SW-1:0]      s2_sig;
  logic signed [11:0] s2_e;

  // A zero magnitude is the only case where the hidden bit of s2_sig is clear.
  always_ff @(posedge clk) begin
    if (en) begin
      s2_sign   <= s1_sign;
      s2_guard  <= norm_guard;
      s2_sticky <= norm_sticky;
      s2_sig    <= norm_sig;
      s2_e      <= norm_e;
    end
  end

  logic                  round_up;
  logic                  mant_carry;
  logic [MANT_W-1:0]     mant_rnd;
  logic signed [12:0]    e_fin;
  logic [EXP_W+MANT_W:0] fp_nxt;
  logic [3:0]            flags_nxt;

  always_comb begin
    round_up                = s2_guard & (s2_sticky | s2_sig[0]);
    {mant_carry, mant_rnd}  = {1'b0, s2_sig[MANT_W-1:0]} + SW'(round_up);
    e_fin                   = $signed({s2_e[11], s2_e}) + $signed({12'd0, mant_carry});
    fp_nxt                  = '0;
    flags_nxt               = 4'b0000;
    if (!s2_sig[MANT_W]) begin
      flags_nxt = 4'b0001;
    end else if (int'(e_fin) >= EMAX) begin
      fp_nxt    = {s2_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      flags_nxt = 4'b1010;
    end else if (int'(e_fin) <= 0) begin
      fp_nxt    = {s2_sign, {(EXP_W + MANT_W){1'b0}}};
      flags_nxt = 4'b1100;
    end else begin
      fp_nxt    = {s2_sign, e_fin[EXP_W-1:0], mant_rnd};
      flags_nxt = {s2_guard | s2_sticky, 3'b000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_fp    <= '0;
      out_flags <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_fp    <= fp_nxt;
        out_flags <= flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fixed_to_fp_pipe.sv
// Directed bench for fixed_to_fp_pipe: an FP32 instance and a BF16 instance share
// the same input stimulus; expected encodings are worked out by hand.
module tb_fixed_to_fp_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [50:0] in_fixed;
  logic [7:0]  in_exp;
  logic        in_ready, out_valid;
  logic [31:0] out_fp;
  logic [3:0]  out_flags;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_fp;
  logic [3:0]  b_out_flags;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fixed_to_fp_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fixed(in_fixed), .in_exp(in_exp), .out_valid(out_valid),
    .out_ready(out_ready), .out_fp(out_fp), .out_flags(out_flags)
  );

  fixed_to_fp_pipe #(.DATA_WIDTH(51), .FIXED_POINT(46), .EXP_W(8), .MANT_W(7)) dut_bf16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_fixed(in_fixed), .in_exp(in_exp), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_fp(b_out_fp), .out_flags(b_out_flags)
  );

  // Drives one beat, then leaves the bench at the negedge after the third rising edge.
  task automatic send_one(input logic [50:0] f, input logic [7:0] e);
    @(negedge clk);
    in_valid = 1'b1; in_fixed = f; in_exp = e; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_fp !== 32'h0 || out_flags !== 4'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b fp=%h flags=%b ready=%b required 0/00000000/0000/1",
               out_valid, out_fp, out_flags, in_ready);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_valid = 1'b1; in_fixed = 51'd1 << 46; in_exp = 8'd0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_c1: out_valid=%b required 0", out_valid); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_c2: out_valid=%b required 0", out_valid); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_fp !== 32'h3F800000 || out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL one: valid=%b fp=%h flags=%b required 1/3f800000/0000", out_valid, out_fp, out_flags);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_beat_dup: out_valid=%b required 0", out_valid); end

    send_one(-(51'd1 << 46), 8'd0);
    vectors++;
    if (out_valid !== 1'b1 || out_fp !== 32'hBF800000 || out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL minus_one: valid=%b fp=%h flags=%b required 1/bf800000/0000", out_valid, out_fp, out_flags);
    end
    send_one(51'd3 << 46, 8'd0);
    vectors++;
    if (out_valid !== 1'b1 || out_fp !== 32'h40400000 || out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL three: valid=%b fp=%h flags=%b required 1/40400000/0000", out_valid, out_fp, out_flags);
    end
    // 5 * 2^-46 needs a left shift: exponent 83, mantissa 0x200000
    send_one(51'd5, 8'd0);
    vectors++;
    if (out_fp !== 32'h29A00000 || out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL small_left_shift: fp=%h flags=%b required 29a00000/0000", out_fp, out_flags);
    end
  endtask

  task automatic test_rounding();
    send_one((51'd1 << 47) | (51'd1 << 23), 8'd0);
    vectors++;
    if (out_fp !== 32'h40000000 || out_flags !== 4'b1000) begin
      miscompares++;
      $display("FAIL tie_even_down: fp=%h flags=%b required 40000000/1000", out_fp, out_flags);
    end
    send_one((51'd1 << 47) | (51'd1 << 24) | (51'd1 << 23), 8'd0);
    vectors++;
    if (out_fp !== 32'h40000002 || out_flags !== 4'b1000) begin
      miscompares++;
      $display("FAIL tie_odd_up: fp=%h flags=%b required 40000002/1000", out_fp, out_flags);
    end
    // 48 ones: rounds up into the next binade, exactly 4.0 with inexact
    send_one(51'h0FFFFFFFFFFFF, 8'd0);
    vectors++;
    if (out_fp !== 32'h40800000 || out_flags !== 4'b1000) begin
      miscompares++;
      $display("FAIL round_carry: fp=%h flags=%b required 40800000/1000", out_fp, out_flags);
    end
    // most-negative input is -2^50 * 2^-46 = -16.0
    send_one(51'd1 << 50, 8'd0);
    vectors++;
    if (out_fp !== 32'hC1800000 || out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL most_negative: fp=%h flags=%b required c1800000/0000", out_fp, out_flags);
    end
  endtask

  task automatic test_range();
    send_one(51'd1 << 46, 8'd127);
    vectors++;
    if (out_fp !== 32'h7F000000 || out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL max_exp_254: fp=%h flags=%b required 7f000000/0000", out_fp, out_flags);
    end
    send_one(51'd1 << 49, 8'd127);
    vectors++;
    if (out_fp !== 32'h7F800000 || out_flags !== 4'b1010) begin
      miscompares++;
      $display("FAIL overflow_pos: fp=%h flags=%b required 7f800000/1010", out_fp, out_flags);
    end
    send_one(51'd1 << 50, 8'd127);
    vectors++;
    if (out_fp !== 32'hFF800000 || out_flags !== 4'b1010) begin
      miscompares++;
      $display("FAIL overflow_neg: fp=%h flags=%b required ff800000/1010", out_fp, out_flags);
    end
    send_one(51'd1 << 46, 8'h82);
    vectors++;
    if (out_fp !== 32'h00800000 || out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL min_normal: fp=%h flags=%b required 00800000/0000", out_fp, out_flags);
    end
    send_one(51'd1 << 46, 8'h81);
    vectors++;
    if (out_fp !== 32'h00000000 || out_flags !== 4'b1100) begin
      miscompares++;
      $display("FAIL exp_zero_flush: fp=%h flags=%b required 00000000/1100", out_fp, out_flags);
    end
    send_one(51'd1, 8'h80);
    vectors++;
    if (out_fp !== 32'h00000000 || out_flags !== 4'b1100) begin
      miscompares++;
      $display("FAIL underflow_pos: fp=%h flags=%b required 00000000/1100", out_fp, out_flags);
    end
    send_one({51{1'b1}}, 8'h80);
    vectors++;
    if (out_fp !== 32'h80000000 || out_flags !== 4'b1100) begin
      miscompares++;
      $display("FAIL underflow_neg: fp=%h flags=%b required 80000000/1100", out_fp, out_flags);
    end
    send_one(51'd0, 8'd5);
    vectors++;
    if (out_fp !== 32'h00000000 || out_flags !== 4'b0001) begin
      miscompares++;
      $display("FAIL zero: fp=%h flags=%b required 00000000/0001", out_fp, out_flags);
    end
  endtask

  task automatic test_bf16();
    send_one(51'd1 << 46, 8'd0);
    vectors++;
    if (b_out_valid !== 1'b1 || b_out_fp !== 16'h3F80 || b_out_flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL bf16_one: valid=%b fp=%h flags=%b required 1/3f80/0000", b_out_valid, b_out_fp, b_out_flags);
    end
    send_one((51'd1 << 46) | (51'd1 << 38), 8'd0);
    vectors++;
    if (b_out_fp !== 16'h3F80 || b_out_flags !== 4'b1000) begin
      miscompares++;
      $display("FAIL bf16_tie_even: fp=%h flags=%b required 3f80/1000", b_out_fp, b_out_flags);
    end
    send_one((51'd1 << 46) | (51'd1 << 39) | (51'd1 << 38), 8'd0);
    vectors++;
    if (b_out_fp !== 16'h3F82 || b_out_flags !== 4'b1000) begin
      miscompares++;
      $display("FAIL bf16_tie_odd: fp=%h flags=%b required 3f82/1000", b_out_fp, b_out_flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv [10];
    int          n_in, n_out, cyc, extra;
    logic        stalled;
    logic [31:0] held;
    expv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    n_in = 0; n_out = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (n_out < 10 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (n_in < 10);
      in_fixed  = 51'(n_in + 1) << 46;
      in_exp    = 8'd0;
      #1;
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_fp !== held) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b fp=%h required 1/%h", out_valid, out_fp, held);
        end
      end
      vectors++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        miscompares++;
        $display("FAIL in_ready_rule: in_ready=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (out_fp !== expv[n_out] || out_flags !== 4'b0000) begin
          miscompares++;
          $display("FAIL stream_beat%0d: fp=%h flags=%b required %h/0000", n_out, out_fp, out_flags, expv[n_out]);
        end
        n_out++;
      end
      stalled = out_valid && !out_ready;
      held    = out_fp;
      if (in_valid && in_ready) n_in++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (n_out != 10) begin
      miscompares++;
      $display("FAIL stream_timeout: beats_out=%0d required 10", n_out);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL stream_duplicate: extra_beats=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_exp = 8'd0; in_fixed = 51'd1 << 46;
    @(negedge clk); in_fixed = 51'd2 << 46;
    @(negedge clk); in_fixed = 51'd3 << 46;
    @(negedge clk); in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL inflight_before_reset: out_valid=%b required 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_fp !== 32'h0 || out_flags !== 4'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b fp=%h flags=%b ready=%b required 0/00000000/0000/1",
               out_valid, out_fp, out_flags, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || b_out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL stale_after_reset: valid_cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_fixed = '0; in_exp = '0;
    #22 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_bf16();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
